// File: rtl/eth_pkg.sv
// eth_pkg: shared CRC-32 constants and FCS generator state encoding
package eth_pkg;

    localparam logic [31:0] CRC32_POLY_REFL  = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT       = 32'hFFFF_FFFF;
    localparam int          PREAMBLE_LEN_DEF = 8;

    typedef enum logic [1:0] {IDLE, SKIP, ACCUM, EMIT} fcs_state_t;

endpackage

// File: rtl/fcs_tx_gen_crc32_d8.sv
// crc32_d8: combinational reflected CRC-32 update over one byte, LSB first
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    // unroll eight serial shift/XOR steps into one parallel update
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++)
            crc_out = (crc_out >> 1) ^ ((crc_out[0] ^ d[i]) ? CRC32_POLY_REFL : 32'h0);
    end

endmodule

// File: rtl/fcs_tx_gen.sv
// fcs_tx_gen: snoops the TX mux byte stream and emits the Ethernet FCS; optional FCS_TX_ERR_INJ_EN enables byte-0 corruption
module fcs_tx_gen
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = PREAMBLE_LEN_DEF
)
(
    input  logic       aclk,
    input  logic       areset,
    input  logic       frame_start,
    input  logic       data_valid,
    input  logic [7:0] data_in,
    input  logic       fcs_start,
    input  logic       fcs_corrupt,
    output logic [7:0] fcs_tx_data,
    output logic       fcs_tx_done,
    output logic       fcs_busy
);

    localparam logic [2:0] SKIP_LAST = 3'(PREAMBLE_LEN - 1);

    fcs_state_t  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] fcs_q, fcs_d;
    logic        post_q, post_d;
    logic [31:0] crc_upd, crc_next, inj;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .d       (data_in),
        .crc_out (crc_upd)
    );

    assign crc_next = data_valid ? crc_upd : crc_q;

`ifdef FCS_TX_ERR_INJ_EN
    assign inj = {24'h0, {8{fcs_corrupt}}};
`else
    logic unused_corrupt;
    assign unused_corrupt = fcs_corrupt;
    assign inj = 32'h0;
`endif

    // next-state: frame_start restarts from any state and overrides fcs_start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        crc_d   = crc_q;
        fcs_d   = fcs_q;
        post_d  = fcs_tx_done;
        if (frame_start) begin
            state_d = SKIP;
            cnt_d   = 3'd0;
            crc_d   = CRC32_INIT;
        end else begin
            case (state_q)
                SKIP: begin
                    if (fcs_start) begin
                        state_d = EMIT;
                        idx_d   = 2'd0;
                        fcs_d   = ~crc_q ^ inj;
                    end else if (data_valid) begin
                        cnt_d   = cnt_q + 3'd1;
                        state_d = (cnt_q == SKIP_LAST) ? ACCUM : SKIP;
                    end
                end
                ACCUM: begin
                    crc_d = crc_next;
                    if (fcs_start) begin
                        state_d = EMIT;
                        idx_d   = 2'd0;
                        fcs_d   = ~crc_next ^ inj;
                    end
                end
                EMIT: begin
                    idx_d   = idx_q + 2'd1;
                    state_d = (idx_q == 2'd3) ? IDLE : EMIT;
                end
                default: ;
            endcase
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= 2'd0;
            crc_q   <= CRC32_INIT;
            fcs_q   <= 32'h0;
            post_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            crc_q   <= crc_d;
            fcs_q   <= fcs_d;
            post_q  <= post_d;
        end
    end

    assign fcs_tx_data = (state_q == EMIT) ? fcs_q[8*idx_q +: 8] : 8'h00;
    assign fcs_tx_done = (state_q == EMIT) && (idx_q == 2'd3);
    assign fcs_busy    = (state_q != IDLE) || post_q;

endmodule
